multi_timer: RTL

//  Memory-mapped bank of NCH independent down-counting timers on the CPU bridge.
//  - Generalises the single-channel CTRL/PRESET/COUNT timer.
//  - Adds per-channel prescaler, one-shot / auto-reload / free-run modes, a W1C STATUS register,
//    and per-channel plus aggregated interrupt requests.
//  - Sits beside the other bridge devices and drives the CP0 hardware-interrupt input.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_channel.sv | 119 +++++++++++
 rtl/multi_timer.sv | 65 ++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register offsets, mode encodings and CTRL field positions for the timer bank.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_FREERUN = 2'b10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam int CTRL_DIV  = 8;

    localparam int STAT_PEND = 0;
    localparam int STAT_RUN  = 1;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/STATUS, prescaler and pending flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] din,
    output logic [31:0] rd_ctrl,
    output logic [31:0] rd_preset,
    output logic [31:0] rd_count,
    output logic [31:0] rd_status,
    output logic        irq
);

    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [7:0]       div_q, div_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             pend_q, pend_d;

    logic wr_ctrl, wr_preset, wr_status, tick;
    logic unused_din;

    assign wr_ctrl    = we && (sel == REG_CTRL);
    assign wr_preset  = we && (sel == REG_PRESET);
    assign wr_status  = we && (sel == REG_STATUS);
    assign tick       = en_q && (pre_q == PRE_W'(div_q));
    assign unused_din = ^din;

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        div_d    = div_q;
        preset_d = preset_q;
        count_d  = count_q;
        pre_d    = '0;
        pend_d   = pend_q;

        if (en_q && !tick) pre_d = pre_q + PRE_W'(1);

        if (wr_status && din[STAT_PEND]) pend_d = 1'b0;

        // Register writes take priority over a tick landing on the same edge;
        // an expiry placed after the W1C makes set win over clear.
        if (tick && !wr_ctrl && !wr_preset) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                pend_d = 1'b1;
                case (mode_q)
                    MODE_RELOAD:  count_d = preset_q;
                    MODE_FREERUN: count_d = '1;
                    default:      en_d    = 1'b0;
                endcase
            end
        end

        if (wr_ctrl) begin
            en_d   = din[CTRL_EN];
            mode_d = din[CTRL_MODE +: 2];
            im_d   = din[CTRL_IM];
            div_d  = din[CTRL_DIV +: 8];
            pre_d  = '0;
        end

        if (wr_preset) begin
            preset_d = din[WIDTH-1:0];
            count_d  = din[WIDTH-1:0];
            pre_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            mode_q   <= '0;
            im_q     <= 1'b0;
            div_q    <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pre_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            div_q    <= div_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        rd_ctrl                   = '0;
        rd_ctrl[CTRL_EN]          = en_q;
        rd_ctrl[CTRL_MODE +: 2]   = mode_q;
        rd_ctrl[CTRL_IM]          = im_q;
        rd_ctrl[CTRL_DIV +: 8]    = div_q;
        rd_status                 = '0;
        rd_status[STAT_PEND]      = pend_q;
        rd_status[STAT_RUN]       = en_q;
    end

    assign rd_preset = 32'(preset_q);
    assign rd_count  = 32'(count_q);
    assign irq       = pend_q && im_q;

endmodule

// File: rtl/multi_timer.sv
// Bank of NCH timer channels on the CPU bridge: address decode, read mux and interrupt OR.
module multi_timer
    import timer_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 32,
    parameter int PRE_W = 8,
    parameter int CH_W  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH_W+1:0] addr,
    input  logic [31:0]     Din,
    input  logic            we,
    output logic [31:0]     Dout,
    output logic [NCH-1:0]  irq,
    output logic            IntReq
);

    logic [CH_W-1:0] ch_sel;
    logic [1:0]      reg_sel;
    logic [31:0]     rd_ctrl   [NCH];
    logic [31:0]     rd_preset [NCH];
    logic [31:0]     rd_count  [NCH];
    logic [31:0]     rd_status [NCH];

    assign ch_sel  = addr[CH_W+1:2];
    assign reg_sel = addr[1:0];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH),
            .PRE_W (PRE_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .we        (we && (ch_sel == CH_W'(g))),
            .sel       (reg_sel),
            .din       (Din),
            .rd_ctrl   (rd_ctrl[g]),
            .rd_preset (rd_preset[g]),
            .rd_count  (rd_count[g]),
            .rd_status (rd_status[g]),
            .irq       (irq[g])
        );
    end

    // Channel indices with no instance behind them read as zero.
    always_comb begin
        Dout = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   Dout = rd_ctrl[i];
                    REG_PRESET: Dout = rd_preset[i];
                    REG_COUNT:  Dout = rd_count[i];
                    REG_STATUS: Dout = rd_status[i];
                endcase
            end
        end
    end

    assign IntReq = |irq;

endmodule
